// File: rtl/maj_aoi_eval_sched.sv
// maj_aoi_eval_sched: round-robin shared 2-stage MAJI/AOI322 evaluator with valid/ready result channel.
// Define MAJ_AOI_EVAL_CNT_EN to add the saturating completion counter (eval_cnt, cnt_clr).
module maj_aoi_eval_sched #(
   parameter int NUM_REQ = 4,
   parameter int ID_W = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [5*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [ID_W-1:0]      res_id,
   output logic                 res_data,
   output logic                 busy
`ifdef MAJ_AOI_EVAL_CNT_EN
   ,
   input  logic                 cnt_clr,
   output logic [15:0]          eval_cnt
`endif
);
   logic            s1_valid;
   logic [ID_W-1:0] s1_id;
   logic [4:0]      s1_op;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] win;
   logic [4:0]      op;
   logic            any_valid;
   logic            s2_adv;
   logic            s1_adv;
   logic            accept;
   logic            n5, n6, n7, y;
   int              idx;

   assign n5 = s1_op[1];
   assign n6 = ~s1_op[3];
   assign n7 = ~((n6 & s1_op[0]) | (n6 & s1_op[1]) | (s1_op[0] & s1_op[1]));
   assign y  = ~((n7 & s1_op[0] & s1_op[2]) | (s1_op[4] & n5) | (s1_op[1] & n6));

   assign any_valid = |req_valid;
   assign s2_adv    = !res_valid || res_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign accept    = s1_adv && any_valid;
   assign busy      = s1_valid || res_valid;

   // Scan from farthest to nearest so the requester closest to ptr wins.
   always_comb begin
      win = '0;
      op  = '0;
      idx = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (req_valid[idx]) begin
            win = ID_W'(idx);
            op  = req_data[5*idx +: 5];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (!rst && accept) req_ready[win] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_id     <= '0;
         s1_op     <= '0;
         res_valid <= 1'b0;
         res_id    <= '0;
         res_data  <= 1'b0;
         ptr       <= '0;
      end else begin
         if (s2_adv) begin
            res_valid <= s1_valid;
            res_id    <= s1_id;
            res_data  <= y;
         end
         if (s1_adv) begin
            s1_valid <= any_valid;
            s1_id    <= win;
            s1_op    <= op;
         end
         if (accept) ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
      end
   end

`ifdef MAJ_AOI_EVAL_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) eval_cnt <= '0;
      else if (cnt_clr) eval_cnt <= '0;
      else if (res_valid && res_ready && eval_cnt != 16'hFFFF) eval_cnt <= eval_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_maj_aoi_eval_sched.sv
// tb_maj_aoi_eval_sched: directed self-checking bench for maj_aoi_eval_sched.
module tb_maj_aoi_eval_sched;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [19:0] req_data;
   logic [3:0]  req_ready;
   logic        res_valid;
   logic        res_ready;
   logic [1:0]  res_id;
   logic        res_data;
   logic        busy;
`ifdef MAJ_AOI_EVAL_CNT_EN
   logic        cnt_clr;
   logic [15:0] eval_cnt;
`endif
   int n_chk = 0;
   int n_fail = 0;
   logic [4:0] ops [4] = '{5'b00000, 5'b00010, 5'b00101, 5'b01101};
   logic       exp_y [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

   maj_aoi_eval_sched #(.NUM_REQ(4), .ID_W(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data), .busy(busy)
`ifdef MAJ_AOI_EVAL_CNT_EN
      , .cnt_clr(cnt_clr), .eval_cnt(eval_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 4'b1111;
      req_data = '0;
      res_ready = 1'b1;
`ifdef MAJ_AOI_EVAL_CNT_EN
      cnt_clr = 1'b0;
`endif
      #1;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_res_valid", 32'(res_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_res_id", 32'(res_id), 32'h0);
      chk("rst_res_data", 32'(res_data), 32'h0);
      tick();
      tick();
      rst = 1'b0;
      req_valid = 4'b0000;
      tick();
      // Function table through requester 0, back-to-back.
      req_valid = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) req_data[4:0] = ops[i];
         else req_valid = 4'b0000;
         #1;
         if (i < 4) chk("fn_ready", 32'(req_ready), 32'h1);
         tick();
         if (i >= 1) begin
            chk("fn_valid", 32'(res_valid), 32'h1);
            chk("fn_id", 32'(res_id), 32'h0);
            chk("fn_data", 32'(res_data), 32'(exp_y[i-1]));
         end
      end
      tick();
      chk("fn_drain_valid", 32'(res_valid), 32'h0);
      chk("fn_drain_busy", 32'(busy), 32'h0);
      // Reset while both stages are full.
      req_data = {ops[3], ops[2], ops[1], ops[0]};
      req_valid = 4'b1111;
      res_ready = 1'b0;
      tick();
      tick();
      chk("mid_busy_pre", 32'(busy), 32'h1);
      chk("mid_valid_pre", 32'(res_valid), 32'h1);
      chk("mid_stall_ready", 32'(req_ready), 32'h0);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(res_valid), 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_ready", 32'(req_ready), 32'h0);
      #2;
      rst = 1'b0;
      res_ready = 1'b1;
      #1;
      // Round robin with all requesters active.
      for (int k = 0; k < 8; k++) begin
         chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
         tick();
         if (k >= 1) begin
            chk("rr_valid", 32'(res_valid), 32'h1);
            chk("rr_id", 32'(res_id), 32'((k - 1) % 4));
            chk("rr_data", 32'(res_data), 32'(exp_y[(k - 1) % 4]));
         end
      end
      req_valid = 4'b0000;
      tick();
      chk("rr_last_id", 32'(res_id), 32'h3);
      chk("rr_last_data", 32'(res_data), 32'(exp_y[3]));
      tick();
      chk("rr_idle", 32'(busy), 32'h0);
      // Backpressure with requesters 1 and 2.
      req_valid = 4'b0110;
      res_ready = 1'b0;
      #1;
      chk("bp_ready1", 32'(req_ready), 32'h2);
      tick();
      req_valid = 4'b0100;
      #1;
      chk("bp_ready2", 32'(req_ready), 32'h4);
      tick();
      req_valid = 4'b0110;
      for (int j = 0; j < 5; j++) begin
         #1;
         chk("bp_stall_ready", 32'(req_ready), 32'h0);
         chk("bp_stall_valid", 32'(res_valid), 32'h1);
         chk("bp_stall_id", 32'(res_id), 32'h1);
         chk("bp_stall_data", 32'(res_data), 32'(exp_y[1]));
         tick();
      end
      req_valid = 4'b0000;
      res_ready = 1'b1;
      tick();
      chk("bp_rel_valid", 32'(res_valid), 32'h1);
      chk("bp_rel_id", 32'(res_id), 32'h2);
      chk("bp_rel_data", 32'(res_data), 32'(exp_y[2]));
      tick();
      chk("bp_rel_empty", 32'(res_valid), 32'h0);
      chk("bp_rel_busy", 32'(busy), 32'h0);
      // Sparse requests: bring ptr to 1, then only requester 3.
      req_valid = 4'b0001;
      #1;
      chk("sp_ready0", 32'(req_ready), 32'h1);
      tick();
      req_valid = 4'b1000;
      #1;
      chk("sp_ready3", 32'(req_ready), 32'h8);
      tick();
      chk("sp_res0_id", 32'(res_id), 32'h0);
      req_valid = 4'b1001;
      #1;
      chk("sp_wrap_ready", 32'(req_ready), 32'h1);
      tick();
      chk("sp_res3_id", 32'(res_id), 32'h3);
      chk("sp_res3_data", 32'(res_data), 32'(exp_y[3]));
      req_valid = 4'b0000;
      tick();
      chk("sp_res0b_id", 32'(res_id), 32'h0);
      chk("sp_res0b_data", 32'(res_data), 32'(exp_y[0]));
      tick();
      chk("sp_idle", 32'(busy), 32'h0);
`ifdef MAJ_AOI_EVAL_CNT_EN
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("cnt_clr", 32'(eval_cnt), 32'h0);
      req_valid = 4'b0001;
      repeat (10) tick();
      req_valid = 4'b0000;
      tick();
      tick();
      chk("cnt_ten", 32'(eval_cnt), 32'd10);
      req_valid = 4'b0001;
      tick();
      tick();
      cnt_clr = 1'b1;
      req_valid = 4'b0000;
      tick();
      cnt_clr = 1'b0;
      chk("cnt_clr_wins", 32'(eval_cnt), 32'h0);
      tick();
      tick();
      force dut.eval_cnt = 16'hFFFE;
      #1;
      release dut.eval_cnt;
      req_valid = 4'b0001;
      repeat (3) tick();
      req_valid = 4'b0000;
      tick();
      tick();
      chk("cnt_sat", 32'(eval_cnt), 32'hFFFF);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/maj_aoi_eval_sched.md
Name: maj_aoi_eval_sched

Overview:
- Shares one registered evaluation unit between NUM_REQ requesters. The unit computes the 5-input MAJI/AOI322 logic cone used by our ASAP7 fake-netlist cells.
- A round-robin arbiter picks one requester per cycle. The winner's operand goes into a 2-stage pipeline.
- The result returns with the requester's ID over a valid/ready output channel.
- Sits between operand producers and the evaluation datapath, which it sequences and arbitrates.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester ID. Must equal clog2(NUM_REQ).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_data  input  5*NUM_REQ  operand a[4:0] for requester i, in bits [5i+4:5i].
- req_ready  output  NUM_REQ  per-requester accept. One-hot or zero.
- res_valid  output  1  result valid.
- res_ready  input  1  downstream accepts result.
- res_id  output  ID_W  requester index of the result.
- res_data  output  1  evaluated function value.
- busy  output  1  high when any pipeline stage holds data.

Behaviour:
- Function, computed combinationally from the stage-1 register:
  - n5=a1; n6=~a3.
  - n7=~MAJ(n6,a0,a1).
  - y=~((n7&a0&a2)|(a4&n5)|(a1&n6)).
- Reset, asynchronous, any time including mid-operation:
  - s1_valid=0, res_valid=0, res_id=0, res_data=0, busy=0.
  - RR pointer=0. req_ready=0 while rst is high.
  - In-flight operands are discarded, not replayed.
- Pipeline:
  - S1 holds {valid, id, operand}. S2 is the output register {res_valid, res_id, res_data}.
  - s2_adv = !res_valid | res_ready.
  - s1_adv = !s1_valid | s2_adv.
  - When s2_adv: S2 loads S1 (res_valid<=s1_valid).
- Accept:
  - accept = s1_adv & (|req_valid).
  - req_ready[w]=1 only for winner w, only when s1_adv. Every other req_ready bit is 0.
  - req_ready may depend combinationally on req_valid and res_ready.
- Handshake:
  - Transfer on req_valid[i]&req_ready[i].
  - Requesters hold req_valid and req_data stable until accepted.
  - Downstream sees res_id/res_data stable while res_valid&!res_ready.
- Latency: a transfer at edge T produces res_valid=1 after edge T+1, i.e. 2 cycles. Throughput is 1 result/cycle with res_ready held high.
- Round-robin arbitration:
  - Winner = first i with req_valid[i], searching ptr, ptr+1, … mod NUM_REQ.
  - On accept, ptr <= winner+1 mod NUM_REQ.
  - No accept, or a stall: ptr unchanged.
- Stall: res_valid&!res_ready with s1_valid=1 means both stages hold and all req_ready=0. No data is lost or duplicated.
- Simultaneous events: the output handshake and an accept in the same cycle are both honoured. S1→S2 and request→S1 move together.
- busy = s1_valid | res_valid.
- Fully synchronous apart from rst. No combinational path from req_data to res_*.

Optional Feature:
- Macro: MAJ_AOI_EVAL_CNT_EN.
- When defined:
  - Adds output eval_cnt [15:0]: a count of completed results (res_valid&res_ready).
  - Saturates at 16'hFFFF with no wrap. Reset value 0 (asynchronous).
  - Adds input cnt_clr, synchronous clear. If clear and a completion coincide, clear wins and eval_cnt=0.
- When undefined: the ports and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset mid-stream:
  - Stimulus: rst pulse while s1_valid=1 and res_valid=1.
  - Response: res_valid=0, busy=0 immediately; next accept goes to requester 0 first.
- Function values, single requester 0, res_ready=1:

  | operand | res_data |
  |---|---|
  | 5'b00000 | 1 |
  | 5'b00010 | 0 |
  | 5'b00101 | 1 |
  | 5'b01101 | 0 |

  Results come out in order, each 2 cycles after its accept, back-to-back with res_id=0.
- Round-robin fairness:
  - Stimulus: all 4 req_valid held high, res_ready=1.
  - Response: grant order 0,1,2,3,0,1…; res_id follows the same order; one result per cycle.
- Backpressure:
  - Stimulus: res_ready=0 for 5 cycles with requesters 1 and 2 valid.
  - Response: exactly two operands captured, then all req_ready=0.
  - Release: results id1 then id2, values unchanged; no drop or duplicate.
- Sparse requests:
  - Stimulus: only requester 3 valid, ptr=1.
  - Response: requester 3 granted; ptr becomes 0; next simultaneous request from 0 and 3 grants 0.
- With MAJ_AOI_EVAL_CNT_EN:
  - 10 completions → eval_cnt=10.
  - cnt_clr asserted in the same cycle as a completion → eval_cnt=0.
  - Forced preload 16'hFFFE plus 3 completions → 16'hFFFF.
